// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle ARM main control FSM.
//   - state_t: 4-bit state encoding (FETCH = 0, FAULT = 4'hA), also driven
//     out on the debug State port.
//   - Op field encodings for Instr[27:26].
//   - Select constants for the ALUSrcA, ALUSrcB and ResultSrc muxes.
//   - is_access(): true for the states that hold a memory access open.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'h0,
    DECODE   = 4'h1,
    MEMADR   = 4'h2,
    MEMREAD  = 4'h3,
    MEMWB    = 4'h4,
    MEMWRITE = 4'h5,
    EXECUTER = 4'h6,
    EXECUTEI = 4'h7,
    ALUWB    = 4'h8,
    BRANCH   = 4'h9,
    FAULT    = 4'hA
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCA_RN  = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [1:0] SRCA_PCD = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // States that wait on MemReady and are therefore timed by the wait counter.
  function automatic logic is_access(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: saturating wait-state counter for memory accesses.
//   clk      processor clock
//   reset    synchronous, active-low reset (clears the count)
//   clr      clear the count this edge (has priority over inc)
//   inc      count one more stall cycle
//   expired  count has reached WAIT_MAX; tied low when WAIT_MAX == 0
module mc_wait_timer #(
  parameter int WAIT_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_MAX[WAIT_W-1:0];

  logic [WAIT_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;   // holds at all-ones instead of wrapping
    end
  end

  assign expired = (WAIT_MAX != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: main control FSM of the multi-cycle ARM processor.
// Sequences fetch / decode / memory / execute / writeback with a MemReady
// handshake and a wait-state timeout that drops into a sticky FAULT state.
//   Inputs : clk, reset (sync, active low), Op, Funct, CondEx, MemReady
//   Strobes: MemReq, MemW, IRWrite, NextPC, RegW, Branch, ALUOp
//            (all forced low while reset is low)
//   Selects: AdrSrc, ALUSrcA, ALUSrcB, ResultSrc
//   Status : Fault (in FAULT), State (current state code)
module mc_mainfsm
  import mc_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       Fault,
  output logic [3:0] State
);

  state_t state, state_nxt;
  logic   in_access, expired, timeout;
  logic   mem_req, mem_w, ir_write, next_pc, reg_w, branch, alu_op;

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // The counter sits at zero outside access states, so it is already clear
  // on entry; inside them any cycle with MemReady high clears it again.
  assign in_access = is_access(state);
  assign timeout   = in_access && !MemReady && expired;

  mc_wait_timer #(
    .WAIT_W  (WAIT_W),
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_access || MemReady),
    .inc    (in_access && !MemReady),
    .expired(expired)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_nxt = state;
    mem_req   = 1'b0;
    mem_w     = 1'b0;
    ir_write  = 1'b0;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_RN;
    ALUSrcB   = SRCB_RM;
    ResultSrc = RES_ALUOUT;
    Fault     = 1'b0;

    unique case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ir_write  = MemReady;
        next_pc   = MemReady;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PCD;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM:  state_nxt = MEMADR;
          OP_DP:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_nxt = BRANCH;
          default: state_nxt = FAULT;   // undefined instruction class
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        if (!CondEx)       state_nxt = FETCH;
        else if (Funct[0]) state_nxt = MEMREAD;
        else               state_nxt = MEMWRITE;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (MemReady) state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = CondEx;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_w   = 1'b1;
        AdrSrc  = 1'b1;
        if (MemReady) state_nxt = FETCH;
      end
      EXECUTER: begin
        ALUSrcB   = SRCB_RM;
        alu_op    = 1'b1;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB   = SRCB_IMM;
        alu_op    = 1'b1;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_w     = CondEx;
        state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = CondEx;
        state_nxt = FETCH;
      end
      FAULT: begin
        Fault     = 1'b1;
        state_nxt = FAULT;
      end
      default: state_nxt = FAULT;       // unused encodings are treated as faults
    endcase

    if (timeout) state_nxt = FAULT;
  end

  // Strobes are gated by reset so nothing fires while the FSM is held.
  assign MemReq  = reset & mem_req;
  assign MemW    = reset & mem_w;
  assign IRWrite = reset & ir_write;
  assign NextPC  = reset & next_pc;
  assign RegW    = reset & reg_w;
  assign Branch  = reset & branch;
  assign ALUOp   = reset & alu_op;
  assign State   = state;

endmodule

// File: doc/mc_mainfsm.md
# mc_mainfsm

Main control state machine for the multi-cycle ARM processor, replacing the fixed-latency sequencer inside the controller. It sequences fetch, decode, memory, execute and writeback steps. It also adds two things the current controller lacks: a memory ready handshake for wait states, and a parametrised wait-state timeout that forces a sticky fault state. It sits between the instruction register and the datapath mux/enable controls, alongside the condition-check logic.

## Interface
- WAIT_W, 8, width of the wait-state counter
- WAIT_MAX, 255, stall cycles tolerated per access before faulting; 0 disables the timeout; must be < 2^WAIT_W
- clk  in  1  processor clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; Funct[5]=I, Funct[0]=L/S
- CondEx  in  1  condition-pass from condition logic, valid from DECODE onward
- MemReady  in  1  memory accepted/returned the current access this cycle
- MemReq  out  1  memory access in progress
- MemW  out  1  write strobe
- IRWrite  out  1  load instruction register
- NextPC  out  1  PC update from fetch increment
- RegW  out  1  register file write
- Branch  out  1  branch taken, PC load from result
- ALUOp  out  1  ALU decode from Funct (0 = add)
- AdrSrc  out  1  0 = PC, 1 = result
- ALUSrcA  out  2  00 = Rn, 01 = PC, 10 = PC (decode)
- ALUSrcB  out  2  00 = Rm, 01 = ext imm, 10 = const 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- Fault  out  1  sticky fault indicator
- State  out  4  current state code for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, FAULT.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC are set to MemReady. Goes to DECODE when MemReady=1, otherwise stays.
- DECODE: ALUSrcA=10, ALUSrcB=10, ResultSrc=10. Next state by Op:
  - Op 01 goes to MEMADR.
  - Op 00 goes to EXECUTEI if Funct[5]=1, else EXECUTER.
  - Op 10 goes to BRANCH.
  - Op 11 goes to FAULT (undefined instruction).
- MEMADR: ALUSrcB=01. If CondEx=0, go to FETCH with no memory access. Otherwise go to MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Goes to MEMWB on MemReady.
- MEMWB: ResultSrc=01, RegW=CondEx. Goes to FETCH.
- MEMWRITE: MemReq=1, MemW=1, AdrSrc=1. Both stay asserted until MemReady, then go to FETCH.
- EXECUTER: ALUSrcB=00, ALUOp=1. EXECUTEI: ALUSrcB=01, ALUOp=1. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegW=CondEx. Goes to FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=CondEx. Goes to FETCH.
- FAULT: all strobes are 0 and Fault=1. The state holds until reset.
- Wait counter: cleared on entry to FETCH, MEMREAD and MEMWRITE, and whenever MemReady=1. It increments each cycle one of these states sees MemReady=0. When it reaches WAIT_MAX (WAIT_MAX≠0) with MemReady still 0, the next state is FAULT. The counter saturates and never wraps.
- Unlisted outputs are 0 in every state.

## Timing
- Reset: while reset=0, every strobe (MemReq, MemW, IRWrite, NextPC, RegW, Branch, ALUOp) is forced to 0 combinationally. The first edge with reset=0 loads FETCH, clears the counter and clears Fault.
- Reset sampled mid-access (any state, including FAULT) aborts to FETCH on that edge. No write completes unless MemReady was already 1.
- Outputs are Moore, except the MemReady- and CondEx-gated terms listed above.
- Zero-wait latencies:
  - Data processing: 4 cycles (FETCH, DECODE, EXEC, ALUWB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Condition-failed memory op: 3 cycles.
- Each wait state adds exactly 1 cycle.
- With WAIT_MAX=N, the fault is entered after N+1 cycles in the access state with MemReady=0.
- MemReady and reset low in the same cycle: reset wins.

## Structure
- Package mc_pkg holds:
  - the state enum, 4-bit, with FETCH=0 and FAULT=4'hA;
  - Op encodings (OP_DP, OP_MEM, OP_BR);
  - ALUSrcA/ALUSrcB/ResultSrc select constants.
- One sub-module, mc_wait_timer (parametrised counter with clear, increment, saturate and expire), is instantiated once.

## Test plan
- Reset held low 3 cycles with MemReady=1 -> all strobes 0 throughout; on release State=FETCH, Fault=0.
- ADD reg (Op=00, Funct=000100, CondEx=1, MemReady=1) -> FETCH→DECODE→EXECUTER→ALUWB, RegW=1 only in cycle 4, back in FETCH at cycle 5.
- LDR with MemReady low for 2 cycles in both FETCH and MEMREAD -> IRWrite pulses once, MEMWB reached at cycle 9, RegW=1 there.
- STR with CondEx=0 -> MEMADR→FETCH; MemW never asserted, MemReq only in FETCH.
- WAIT_MAX=3, MemReady stuck 0 in MEMWRITE -> MemW high 4 cycles, then State=FAULT, Fault=1 held; reset low one cycle -> FETCH, Fault=0.
- Op=11 in DECODE -> FAULT next cycle; WAIT_MAX=0 with 300 stall cycles -> no fault, remains in FETCH.
